// File: rtl/pdp11_psw_pkg.sv
// Shared PSW definitions: field bit positions, processor mode encodings
// and the trace-trap state type used by psw_state and psw_trace_fsm.
package pdp11_psw_pkg;

    // Field positions inside the 16-bit PSW
    localparam int CUR_MODE_HI  = 15;
    localparam int CUR_MODE_LO  = 14;
    localparam int PREV_MODE_HI = 13;
    localparam int PREV_MODE_LO = 12;
    localparam int PRI_HI       = 7;
    localparam int PRI_LO       = 5;
    localparam int TBIT         = 4;
    localparam int NBIT         = 3;
    localparam int ZBIT         = 2;
    localparam int VBIT         = 1;
    localparam int CBIT         = 0;

    // Processor mode encodings held in the mode fields
    localparam logic [1:0] KERNEL = 2'b00;
    localparam logic [1:0] SUPER  = 2'b01;
    localparam logic [1:0] USER   = 2'b11;

    // Trace-trap sequencing states
    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        PEND
    } trace_state_e;

endpackage

// File: rtl/psw_trace_fsm.sv
// T-bit trace-trap state machine. Arms at instruction start when T is set
// (unless an RTT has asked to skip one instruction), goes pending at
// instruction end and holds trace_req until the trap sequencer accepts it.
module psw_trace_fsm
    import pdp11_psw_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_tbit,
    input  logic i_insn_start,
    input  logic i_insn_done,
    input  logic i_trace_ack,
    input  logic i_trap_load,
    input  logic i_rtt_load,
    output logic o_trace_req
);

    trace_state_e r_state;
    trace_state_e w_next;
    logic         r_rtt_inhibit;
    logic         r_trace_req;

    // State register; reset returns to IDLE from any state
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an instruction start while pending is ignored
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (i_insn_start && i_tbit && !r_rtt_inhibit) begin
                    w_next = ARMED;
                end
            end
            ARMED: begin
                if (i_trap_load) begin
                    w_next = IDLE;
                end else if (i_insn_done) begin
                    w_next = PEND;
                end
            end
            PEND: begin
                if (i_trace_ack) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // RTT inhibit: a set wins over a clear so it covers the following start
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rtt_inhibit <= 1'b0;
        end else if (i_rtt_load) begin
            r_rtt_inhibit <= 1'b1;
        end else if (i_insn_start) begin
            r_rtt_inhibit <= 1'b0;
        end
    end

    // Registered trace request, high whenever the machine sits in PEND
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_trace_req <= 1'b0;
        end else begin
            r_trace_req <= (w_next == PEND);
        end
    end

    assign o_trace_req = r_trace_req;

endmodule

// File: rtl/psw_state.sv
// Architectural Processor Status Word holder and sole writer of the PSW.
// Selects one update source per cycle (trap > RTI/RTT > IO write > SPL > CC)
// and hosts the trace-trap state machine.
// Optional build macro MODE_PROTECT_EN: in non-kernel mode, RTI cannot
// lower the mode or change priority, and IO-page writes are ignored.
module psw_state
    import pdp11_psw_pkg::*;
#(
    parameter logic [15:0] RESET_PSW = 16'o000000,
    parameter logic [15:0] RSVD_MASK = 16'o003400
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        io_wr,
    input  logic        io_addr0,
    input  logic        io_byte_op,
    input  logic [15:0] io_data,
    input  logic        cc_load,
    input  logic [3:0]  cc_mask,
    input  logic [3:0]  cc_in,
    input  logic        rti_load,
    input  logic        rtt,
    input  logic [15:0] rti_data,
    input  logic        trap_load,
    input  logic [15:0] trap_data,
    input  logic        spl_load,
    input  logic [2:0]  spl_level,
    input  logic        insn_start,
    input  logic        insn_done,
    input  logic        trace_ack,
    output logic [15:0] psw,
    output logic        trace_req
);

    localparam logic [15:0] KEEP_MASK = ~RSVD_MASK;

    logic [15:0] r_psw;
    logic [15:0] w_psw_next;
    logic [15:0] w_trap_psw;
    logic [15:0] w_rti_psw;
    logic [15:0] w_io_psw;
    logic [15:0] w_spl_psw;
    logic [15:0] w_cc_psw;
    logic        w_kernel;
    logic        w_rtt_load;

    assign w_kernel = (r_psw[CUR_MODE_HI:CUR_MODE_LO] == KERNEL);

    // Candidate PSW values, one per update source
    always_comb begin
        w_trap_psw = trap_data;
        w_trap_psw[PREV_MODE_HI:PREV_MODE_LO] = r_psw[CUR_MODE_HI:CUR_MODE_LO];
        w_trap_psw = w_trap_psw & KEEP_MASK;

        w_rti_psw = rti_data & KEEP_MASK;
`ifdef MODE_PROTECT_EN
        if (!w_kernel) begin
            w_rti_psw = r_psw & KEEP_MASK;
            w_rti_psw[15:12] = r_psw[15:12] | rti_data[15:12];
            w_rti_psw[4:0] = rti_data[4:0];
        end
`endif

        if (!io_byte_op) begin
            w_io_psw = io_data;
            w_io_psw[TBIT] = r_psw[TBIT];
        end else if (!io_addr0) begin
            w_io_psw = {r_psw[15:8], io_data[7:0]};
            w_io_psw[TBIT] = r_psw[TBIT];
        end else begin
            w_io_psw = {io_data[15:8], r_psw[7:0]};
        end
        w_io_psw = w_io_psw & KEEP_MASK;

        w_spl_psw = r_psw;
        w_spl_psw[PRI_HI:PRI_LO] = spl_level;

        w_cc_psw = r_psw;
        w_cc_psw[NBIT:CBIT] = (r_psw[NBIT:CBIT] & ~cc_mask) | (cc_in & cc_mask);
    end

    // Priority select; the winning source may still decline to change the PSW
    always_comb begin
        w_psw_next = r_psw;
        if (trap_load) begin
            w_psw_next = w_trap_psw;
        end else if (rti_load) begin
            w_psw_next = w_rti_psw;
        end else if (io_wr) begin
`ifdef MODE_PROTECT_EN
            if (w_kernel) begin
                w_psw_next = w_io_psw;
            end
`else
            w_psw_next = w_io_psw;
`endif
        end else if (spl_load) begin
            if (w_kernel) begin
                w_psw_next = w_spl_psw;
            end
        end else if (cc_load) begin
            w_psw_next = w_cc_psw;
        end
    end

    // PSW register
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_psw <= RESET_PSW & KEEP_MASK;
        end else begin
            r_psw <= w_psw_next;
        end
    end

    // An RTT only counts when its load actually wins the cycle
    assign w_rtt_load = rti_load && rtt && !trap_load;

    psw_trace_fsm u_trace (
        .clk          (clk),
        .reset        (reset),
        .i_tbit       (r_psw[TBIT]),
        .i_insn_start (insn_start),
        .i_insn_done  (insn_done),
        .i_trace_ack  (trace_ack),
        .i_trap_load  (trap_load),
        .i_rtt_load   (w_rtt_load),
        .o_trace_req  (trace_req)
    );

    assign psw = r_psw;

endmodule
